// File: rtl/uart_main_ctrl_if.sv
// Host/datapath-facing signal bundle of the UART main control FSM.
// The slave modport is the controller's view; master is the environment's view.
interface uart_main_ctrl_if;
  logic       interrupt_ackn_i;
  logic [7:0] data_rx_i;
  logic [7:0] data_tx_i;
  logic       tx_done_i;
  logic       req_done_i;
  logic       frame_error_i;
  logic       parity_i;
  logic       overrun_error_i;
  logic       configuration_error_i;
  logic       rx_fifo_empty_i;
  logic       tx_fifo_empty_i;
  logic       rx_fifo_read_i;
  logic       tx_fifo_write_i;
  logic       config_req_slv_i;
  logic       config_req_mst_i;
  logic       std_config_i;
  logic [5:0] config_i;
  logic       data_stream_mode_i;
  logic       req_ackn_i;

  logic       STR_en_o;
  logic [5:0] config_o;
  logic       config_req_mst_o;
  logic       data_stream_mode_o;
  logic       configuration_done_o;
  logic       req_ackn_o;
  logic       rx_fifo_read_o;
  logic       tx_fifo_write_o;
  logic [7:0] data_tx_o;
  logic [3:0] error_o;

  modport master (
    output interrupt_ackn_i, data_rx_i, data_tx_i, tx_done_i, req_done_i,
           frame_error_i, parity_i, overrun_error_i, configuration_error_i,
           rx_fifo_empty_i, tx_fifo_empty_i, rx_fifo_read_i, tx_fifo_write_i,
           config_req_slv_i, config_req_mst_i, std_config_i, config_i,
           data_stream_mode_i, req_ackn_i,
    input  STR_en_o, config_o, config_req_mst_o, data_stream_mode_o,
           configuration_done_o, req_ackn_o, rx_fifo_read_o, tx_fifo_write_o,
           data_tx_o, error_o
  );

  modport slave (
    input  interrupt_ackn_i, data_rx_i, data_tx_i, tx_done_i, req_done_i,
           frame_error_i, parity_i, overrun_error_i, configuration_error_i,
           rx_fifo_empty_i, tx_fifo_empty_i, rx_fifo_read_i, tx_fifo_write_i,
           config_req_slv_i, config_req_mst_i, std_config_i, config_i,
           data_stream_mode_i, req_ackn_i,
    output STR_en_o, config_o, config_req_mst_o, data_stream_mode_o,
           configuration_done_o, req_ackn_o, rx_fifo_read_o, tx_fifo_write_o,
           data_tx_o, error_o
  );
endinterface

// File: rtl/uart_main_ctrl.sv
// UART main control FSM: MAIN-state passthrough, sticky error aggregation and
// the master/slave link-configuration handshake (one 8-bit packet per step, acked).
module uart_main_ctrl #(
  parameter logic [7:0] ACKN_PKT   = 8'hFF,
  parameter logic [3:0] PKT_HDR    = 4'hD,
  parameter logic [5:0] STD_CONFIG = 6'b11_00_00
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  uart_main_ctrl_if.slave bus
);
  localparam logic [3:0] MAIN              = 4'd0;
  localparam logic [3:0] REQ_MST           = 4'd1;
  localparam logic [3:0] WAIT_REQ_ACKN_MST = 4'd2;
  localparam logic [3:0] SETUP_MST         = 4'd3;
  localparam logic [3:0] WAIT_TX_MST       = 4'd4;
  localparam logic [3:0] WAIT_ACKN_MST     = 4'd5;
  localparam logic [3:0] REQ_SLV           = 4'd6;
  localparam logic [3:0] SEND_ACKN_SLV     = 4'd7;
  localparam logic [3:0] WAIT_TX_SLV       = 4'd8;
  localparam logic [3:0] SETUP_SLV         = 4'd9;

  logic [3:0] state_reg, state_next;
  logic [1:0] idx_reg, idx_next;
  logic [5:0] shadow_reg, shadow_next;
  logic [5:0] config_reg, config_next;
  logic       end_seen_reg, end_seen_next;
  logic       done_reg, done_next;
  logic       stream_reg;
  logic [3:0] sticky_reg;
  logic       cfg_err;
  logic [3:0] err_now;
  logic [7:0] mst_pkt;
  logic       ack_ready;

  assign ack_ready = !bus.rx_fifo_empty_i && (bus.data_rx_i == ACKN_PKT);

  // Outgoing master packet for the current step; END always carries option 00.
  always_comb begin
    mst_pkt = {PKT_HDR, 2'b11, 2'b00};
    case (idx_reg)
      2'd0:    mst_pkt = {PKT_HDR, 2'b00, shadow_reg[5:4]};
      2'd1:    mst_pkt = {PKT_HDR, 2'b01, shadow_reg[3:2]};
      2'd2:    mst_pkt = {PKT_HDR, 2'b10, shadow_reg[1:0]};
      default: mst_pkt = {PKT_HDR, 2'b11, 2'b00};
    endcase
  end

  always_comb begin
    state_next           = state_reg;
    idx_next             = idx_reg;
    shadow_next          = shadow_reg;
    config_next          = config_reg;
    end_seen_next        = end_seen_reg;
    done_next            = 1'b0;
    cfg_err              = 1'b0;
    bus.STR_en_o         = 1'b0;
    bus.config_req_mst_o = 1'b0;
    bus.req_ackn_o       = 1'b0;
    bus.rx_fifo_read_o   = 1'b0;
    bus.tx_fifo_write_o  = 1'b0;
    bus.data_tx_o        = 8'h00;
    case (state_reg)
      MAIN: begin
        bus.STR_en_o        = 1'b1;
        bus.data_tx_o       = bus.data_tx_i;
        bus.rx_fifo_read_o  = bus.rx_fifo_read_i;
        bus.tx_fifo_write_o = bus.tx_fifo_write_i;
        if (bus.config_req_slv_i) begin
          // Slave shadow starts from the active config so unsent fields persist.
          state_next    = REQ_SLV;
          shadow_next   = config_reg;
          end_seen_next = 1'b0;
        end else if (bus.config_req_mst_i) begin
          state_next  = REQ_MST;
          shadow_next = bus.std_config_i ? STD_CONFIG : bus.config_i;
        end
      end
      REQ_MST: begin
        bus.config_req_mst_o = 1'b1;
        if (bus.req_done_i) state_next = WAIT_REQ_ACKN_MST;
      end
      WAIT_REQ_ACKN_MST: begin
        if (!bus.rx_fifo_empty_i) begin
          bus.rx_fifo_read_o = 1'b1;
          if (ack_ready) begin
            idx_next   = 2'd0;
            state_next = SETUP_MST;
          end else begin
            cfg_err    = 1'b1;
            state_next = MAIN;
          end
        end
      end
      SETUP_MST: begin
        bus.data_tx_o       = mst_pkt;
        bus.tx_fifo_write_o = 1'b1;
        state_next          = WAIT_TX_MST;
      end
      WAIT_TX_MST: begin
        bus.data_tx_o = mst_pkt;
        if (bus.tx_done_i) state_next = WAIT_ACKN_MST;
      end
      WAIT_ACKN_MST: begin
        if (!bus.rx_fifo_empty_i) begin
          bus.rx_fifo_read_o = 1'b1;
          if (!ack_ready) begin
            cfg_err    = 1'b1;
            state_next = MAIN;
          end else if (idx_reg == 2'd3) begin
            config_next = shadow_reg;
            done_next   = 1'b1;
            state_next  = MAIN;
          end else begin
            idx_next   = idx_reg + 2'd1;
            state_next = SETUP_MST;
          end
        end
      end
      REQ_SLV: begin
        bus.req_ackn_o = 1'b1;
        if (bus.req_ackn_i) state_next = SEND_ACKN_SLV;
      end
      SEND_ACKN_SLV: begin
        bus.data_tx_o       = ACKN_PKT;
        bus.tx_fifo_write_o = 1'b1;
        state_next          = WAIT_TX_SLV;
      end
      WAIT_TX_SLV: begin
        bus.data_tx_o = ACKN_PKT;
        if (bus.tx_done_i) begin
          if (end_seen_reg) begin
            config_next = shadow_reg;
            done_next   = 1'b1;
            state_next  = MAIN;
          end else begin
            state_next = SETUP_SLV;
          end
        end
      end
      SETUP_SLV: begin
        if (!bus.rx_fifo_empty_i) begin
          bus.rx_fifo_read_o = 1'b1;
          if (bus.data_rx_i[7:4] != PKT_HDR) begin
            cfg_err    = 1'b1;
            state_next = MAIN;
          end else begin
            state_next = SEND_ACKN_SLV;
            case (bus.data_rx_i[3:2])
              2'b00:   shadow_next[5:4] = bus.data_rx_i[1:0];
              2'b01:   shadow_next[3:2] = bus.data_rx_i[1:0];
              2'b10:   shadow_next[1:0] = bus.data_rx_i[1:0];
              default: end_seen_next    = 1'b1;
            endcase
          end
        end
      end
      default: state_next = MAIN;
    endcase
  end

  assign err_now = {bus.configuration_error_i | cfg_err, bus.overrun_error_i,
                    bus.parity_i, bus.frame_error_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= MAIN;
      idx_reg      <= 2'd0;
      shadow_reg   <= STD_CONFIG;
      config_reg   <= STD_CONFIG;
      end_seen_reg <= 1'b0;
      done_reg     <= 1'b0;
      stream_reg   <= 1'b0;
      sticky_reg   <= 4'h0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      shadow_reg   <= shadow_next;
      config_reg   <= config_next;
      end_seen_reg <= end_seen_next;
      done_reg     <= done_next;
      if (state_reg == MAIN) stream_reg <= bus.data_stream_mode_i;
      // New errors win over a simultaneous acknowledge.
      sticky_reg   <= (sticky_reg & {4{~bus.interrupt_ackn_i}}) | err_now;
    end
  end

  assign bus.config_o             = config_reg;
  assign bus.configuration_done_o = done_reg;
  assign bus.data_stream_mode_o   = stream_reg;
  assign bus.error_o              = sticky_reg | err_now;
endmodule

// File: tb/tb_uart_main_ctrl.sv
// Randomized self-checking bench for uart_main_ctrl; plays host and remote device
// and predicts outputs from the packet format and error rules.
module tb_uart_main_ctrl;
  localparam logic [5:0] STD_CFG = 6'b11_00_00;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [5:0] exp_config;
  logic [3:0] exp_sticky;

  uart_main_ctrl_if u_if();

  uart_main_ctrl dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bus    (u_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Config packet i: header D, id i, field taken MSB-first from cfg; END option 0.
  function automatic logic [7:0] cfg_pkt(input logic [5:0] cfg, input int i);
    logic [1:0] field;
    field = (i == 3) ? 2'b00 : 2'((cfg >> (4 - 2 * i)) & 6'h3);
    return {4'hD, 2'(i), field};
  endfunction

  task automatic idle_inputs();
    u_if.interrupt_ackn_i = 0;      u_if.data_rx_i = 8'h00;
    u_if.data_tx_i = 8'h00;         u_if.tx_done_i = 0;
    u_if.req_done_i = 0;            u_if.frame_error_i = 0;
    u_if.parity_i = 0;              u_if.overrun_error_i = 0;
    u_if.configuration_error_i = 0; u_if.rx_fifo_empty_i = 1;
    u_if.tx_fifo_empty_i = 1;       u_if.rx_fifo_read_i = 0;
    u_if.tx_fifo_write_i = 0;       u_if.config_req_slv_i = 0;
    u_if.config_req_mst_i = 0;      u_if.std_config_i = 0;
    u_if.config_i = 6'h00;          u_if.data_stream_mode_i = 0;
    u_if.req_ackn_i = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_str_en"}, u_if.STR_en_o, 1);
    check_eq({tag, "_config"}, u_if.config_o, STD_CFG);
    check_eq({tag, "_req_mst"}, u_if.config_req_mst_o, 0);
    check_eq({tag, "_done"}, u_if.configuration_done_o, 0);
    check_eq({tag, "_req_ackn"}, u_if.req_ackn_o, 0);
    check_eq({tag, "_tx_write"}, u_if.tx_fifo_write_o, 0);
    check_eq({tag, "_rx_read"}, u_if.rx_fifo_read_o, 0);
    check_eq({tag, "_data_tx"}, u_if.data_tx_o, 8'h00);
    check_eq({tag, "_error"}, u_if.error_o, 4'h0);
  endtask

  task automatic run_master(input bit use_std, input logic [5:0] cfg, input bit abort);
    logic [5:0] want;
    logic [7:0] pkt;
    int hold;
    want = use_std ? STD_CFG : cfg;
    hold = 1 + int'($urandom_range(0, 2));
    u_if.std_config_i = use_std;
    u_if.config_i = cfg;
    u_if.config_req_mst_i = 1;
    tick();
    u_if.config_req_mst_i = 0;
    for (int k = 0; k < hold; k++) begin
      #1;
      check_eq("mst_req_line", u_if.config_req_mst_o, 1);
      check_eq("mst_str_off", u_if.STR_en_o, 0);
      tick();
    end
    u_if.req_done_i = 1;
    tick();
    u_if.req_done_i = 0;
    u_if.rx_fifo_empty_i = 0;
    u_if.data_rx_i = 8'hFF;
    #1;
    check_eq("mst_req_line_off", u_if.config_req_mst_o, 0);
    check_eq("mst_req_ack_pop", u_if.rx_fifo_read_o, 1);
    tick();
    u_if.rx_fifo_empty_i = 1;
    for (int i = 0; i < 4; i++) begin
      pkt = cfg_pkt(want, i);
      #1;
      check_eq("mst_pkt", u_if.data_tx_o, pkt);
      check_eq("mst_pkt_write", u_if.tx_fifo_write_o, 1);
      $display("master pkt %0d: %02h", i, u_if.data_tx_o);
      tick();
      u_if.tx_fifo_write_i = 1;
      #1;
      check_eq("mst_host_write_ignored", u_if.tx_fifo_write_o, 0);
      check_eq("mst_pkt_hold", u_if.data_tx_o, pkt);
      u_if.tx_fifo_write_i = 0;
      if (abort) return;
      tick();
      u_if.tx_done_i = 1;
      tick();
      u_if.tx_done_i = 0;
      u_if.rx_fifo_empty_i = 0;
      u_if.data_rx_i = 8'hFF;
      #1;
      check_eq("mst_ack_pop", u_if.rx_fifo_read_o, 1);
      tick();
      u_if.rx_fifo_empty_i = 1;
    end
    #1;
    check_eq("mst_done", u_if.configuration_done_o, 1);
    check_eq("mst_config", u_if.config_o, want);
    check_eq("mst_back_main", u_if.STR_en_o, 1);
    exp_config = want;
    tick();
    check_eq("mst_done_pulse", u_if.configuration_done_o, 0);
  endtask

  task automatic slave_send_ack();
    #1;
    check_eq("slv_ack_data", u_if.data_tx_o, 8'hFF);
    check_eq("slv_ack_write", u_if.tx_fifo_write_o, 1);
    tick();
    #1;
    check_eq("slv_ack_hold", u_if.data_tx_o, 8'hFF);
    check_eq("slv_ack_write_end", u_if.tx_fifo_write_o, 0);
    u_if.tx_done_i = 1;
    tick();
    u_if.tx_done_i = 0;
  endtask

  task automatic run_slave(input logic [7:0] pkts[4], input int n);
    logic [5:0] shadow;
    shadow = exp_config;
    u_if.config_req_slv_i = 1;
    tick();
    u_if.config_req_slv_i = 0;
    #1;
    check_eq("slv_req_ackn", u_if.req_ackn_o, 1);
    check_eq("slv_str_off", u_if.STR_en_o, 0);
    tick();
    #1;
    check_eq("slv_req_ackn_hold", u_if.req_ackn_o, 1);
    u_if.req_ackn_i = 1;
    tick();
    u_if.req_ackn_i = 0;
    slave_send_ack();
    for (int i = 0; i < n; i++) begin
      u_if.rx_fifo_empty_i = 0;
      u_if.data_rx_i = pkts[i];
      #1;
      check_eq("slv_pop", u_if.rx_fifo_read_o, 1);
      $display("slave rx pkt %0d: %02h", i, pkts[i]);
      tick();
      u_if.rx_fifo_empty_i = 1;
      if (pkts[i][7:4] != 4'hD) begin
        #1;
        check_eq("slv_bad_err", u_if.error_o[3], 1);
        check_eq("slv_bad_main", u_if.STR_en_o, 1);
        check_eq("slv_bad_config", u_if.config_o, exp_config);
        u_if.interrupt_ackn_i = 1;
        tick();
        u_if.interrupt_ackn_i = 0;
        #1;
        check_eq("slv_err_cleared", u_if.error_o, 4'h0);
        return;
      end
      case (pkts[i][3:2])
        2'b00: shadow[5:4] = pkts[i][1:0];
        2'b01: shadow[3:2] = pkts[i][1:0];
        2'b10: shadow[1:0] = pkts[i][1:0];
        default: ;
      endcase
      slave_send_ack();
      if (pkts[i][3:2] == 2'b11) begin
        #1;
        check_eq("slv_done", u_if.configuration_done_o, 1);
        check_eq("slv_config", u_if.config_o, shadow);
        exp_config = shadow;
        tick();
        check_eq("slv_done_pulse", u_if.configuration_done_o, 0);
        return;
      end
    end
  endtask

  initial begin
    logic [7:0] dtx;
    logic [3:0] errs;
    logic ack, rd, wr, sm, prev_sm;
    logic [5:0] rcfg;
    logic [7:0] pkts[4];

    idle_inputs();
    exp_config = STD_CFG;
    exp_sticky = 4'h0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    check_eq("reset_stream", u_if.data_stream_mode_o, 0);
    rst_n_i = 1;

    prev_sm = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      dtx = 8'($urandom);
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      errs = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      ack = ($urandom_range(0, 3) == 0);
      sm = 1'($urandom_range(0, 1));
      u_if.data_tx_i = dtx;
      u_if.rx_fifo_read_i = rd;
      u_if.tx_fifo_write_i = wr;
      u_if.frame_error_i = errs[0];
      u_if.parity_i = errs[1];
      u_if.overrun_error_i = errs[2];
      u_if.configuration_error_i = errs[3];
      u_if.interrupt_ackn_i = ack;
      u_if.data_stream_mode_i = sm;
      #1;
      check_eq("main_data_tx", u_if.data_tx_o, dtx);
      check_eq("main_rx_read", u_if.rx_fifo_read_o, rd);
      check_eq("main_tx_write", u_if.tx_fifo_write_o, wr);
      check_eq("main_error", u_if.error_o, exp_sticky | errs);
      check_eq("main_stream", u_if.data_stream_mode_o, prev_sm);
      $display("main cycle %0d: data %02h err_in %h error %h", c, dtx, errs, u_if.error_o);
      exp_sticky = (ack ? 4'h0 : exp_sticky) | errs;
      prev_sm = sm;
    end
    tick();
    idle_inputs();
    u_if.frame_error_i = 1;
    #1;
    check_eq("frame_err_same_cycle", u_if.error_o[0], 1);
    u_if.frame_error_i = 0;
    u_if.interrupt_ackn_i = 1;
    tick();
    u_if.interrupt_ackn_i = 0;
    #1;
    check_eq("err_cleared", u_if.error_o, 4'h0);

    run_master(1, 6'h00, 0);
    run_master(0, 6'b10_01_01, 0);
    for (int i = 0; i < 4; i++) pkts[i] = cfg_pkt(STD_CFG, i);
    run_slave(pkts, 4);
    rcfg = 6'($urandom);
    run_master(0, rcfg, 0);
    rcfg = 6'($urandom);
    for (int i = 0; i < 4; i++) pkts[i] = cfg_pkt(rcfg, i);
    run_slave(pkts, 4);
    pkts[0] = 8'h53;
    run_slave(pkts, 1);

    rcfg = 6'($urandom);
    run_master(0, rcfg, 1);
    u_if.data_tx_i = 8'h00;
    rst_n_i = 0;
    #1;
    check_reset_outputs("midreset");
    tick();
    rst_n_i = 1;
    exp_config = STD_CFG;
    tick();
    u_if.data_tx_i = 8'h5A;
    #1;
    check_eq("post_reset_passthru", u_if.data_tx_o, 8'h5A);
    check_eq("post_reset_config", u_if.config_o, exp_config);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_main_ctrl.md
Name: uart_main_ctrl

Overview:
- Central control FSM of the UART.
- In normal operation it passes host data and FIFO strobes straight through to the TX/RX paths and aggregates receive errors.
- It runs the link-configuration handshake in two roles:
  - Master: this UART proposes a configuration.
  - Slave: the remote device proposes one.
- Every configuration step exchanges one 8-bit packet and waits for an acknowledge packet.

Parameters:
- ACKN_PKT, 8'hFF, acknowledge packet value.
- PKT_HDR, 4'hD, upper nibble of every configuration packet.
- STD_CONFIG, 6'b11_00_00, reset/standard config {data_width, parity_mode, stop_bits}.

Ports:
- clk_i in 1: system clock.
- rst_n_i in 1: asynchronous reset, active low.
- interrupt_ackn_i in 1: clears sticky error_o.
- data_rx_i in 8: head of RX FIFO.
- data_tx_i in 8: host byte to transmit.
- tx_done_i in 1: transmitter finished the current byte.
- req_done_i in 1: transmitter finished driving the config-request condition on the line.
- frame_error_i in 1: receiver frame error.
- parity_i in 1: receiver parity error.
- overrun_error_i in 1: RX FIFO overrun.
- configuration_error_i in 1: external config fault.
- rx_fifo_empty_i in 1: RX FIFO empty.
- tx_fifo_empty_i in 1: TX FIFO empty.
- rx_fifo_read_i in 1: host RX FIFO read strobe.
- tx_fifo_write_i in 1: host TX FIFO write strobe.
- config_req_slv_i in 1: remote config request detected.
- config_req_mst_i in 1: host starts master configuration.
- std_config_i in 1: master sends STD_CONFIG (else config_i).
- config_i in 6: host configuration.
- data_stream_mode_i in 1: host stream-mode select.
- req_ackn_i in 1: host acknowledges a slave request.
- STR_en_o out 1: request-detector enable; high only in MAIN.
- config_o out 6: active configuration.
- config_req_mst_o out 1: orders the transmitter to drive the request condition.
- data_stream_mode_o out 1: registered stream mode.
- configuration_done_o out 1: one-cycle pulse when a configuration completes.
- req_ackn_o out 1: notifies host of a slave request.
- rx_fifo_read_o out 1: RX FIFO pop.
- tx_fifo_write_o out 1: TX FIFO push.
- data_tx_o out 8: byte to TX FIFO.
- error_o out 4: {config, overrun, parity, frame}.

Behaviour:
- Reset values:
  - State MAIN; config_o = STD_CONFIG; sticky errors 0.
  - All strobes and pulses 0; data_tx_o = 0; STR_en_o = 1.
- Packet format: {PKT_HDR, id[1:0], option[1:0]}.
  - IDs: DATA_WIDTH = 00, PARITY_MODE = 01, STOP_BITS = 10, END_CONFIGURATION = 11.
  - The END packet carries option 00.
- MAIN:
  - data_tx_o = data_tx_i, rx_fifo_read_o = rx_fifo_read_i, tx_fifo_write_o = tx_fifo_write_i (all combinational).
  - data_stream_mode_o is registered from data_stream_mode_i.
- error_o = sticky | current error inputs, combinational, so it is visible in the same cycle.
  - Sticky bits set on the inputs; cleared by interrupt_ackn_i.
  - A set and a clear in the same cycle: set wins.
- Priority in MAIN: config_req_slv_i over config_req_mst_i.
- Master flow:
  - MAIN to REQ_MST on config_req_mst_i. REQ_MST: config_req_mst_o = 1 and STR_en_o = 0 until req_done_i, then go to WAIT_REQ_ACKN_MST.
  - WAIT_REQ_ACKN_MST: when !rx_fifo_empty_i and data_rx_i == ACKN_PKT, pulse rx_fifo_read_o and go to SETUP_MST with idx = 0.
  - SETUP_MST: data_tx_o = packet[idx] and pulse tx_fifo_write_o for one cycle, then go to WAIT_TX_MST.
  - Packet order: DATA_WIDTH, PARITY_MODE, STOP_BITS, END. Values come from STD_CONFIG if std_config_i, else config_i.
  - WAIT_TX_MST: hold data_tx_o. On tx_done_i go to WAIT_ACKN_MST.
  - WAIT_ACKN_MST: on ACKN_PKT received (pop it), idx++. After the END ack, update config_o, pulse configuration_done_o and return to MAIN. Otherwise go to SETUP_MST.
- Slave flow:
  - MAIN to REQ_SLV on config_req_slv_i. REQ_SLV: req_ackn_o = 1 until req_ackn_i.
  - SEND_ACKN_SLV: data_tx_o = ACKN_PKT with a one-cycle tx_fifo_write_o pulse; ACKN_PKT stays on data_tx_o through WAIT_TX_SLV.
  - WAIT_TX_SLV: on tx_done_i go to SETUP_SLV, or to MAIN with a configuration_done_o pulse if END was received.
  - SETUP_SLV: when !rx_fifo_empty_i, pop the byte and decode it into a shadow config, then go to SEND_ACKN_SLV.
  - Shadow config is copied to config_o when END is accepted.
- Malformed packets: a bad header, or a non-ACKN byte while waiting for an ack, sets the config error bit. The packet is popped and the FSM returns to MAIN without changing config_o.
- Host FIFO strobes are ignored outside MAIN.
- Reset mid-sequence returns to MAIN with STD_CONFIG.

Test Plan:
- Reset, then 25 random MAIN cycles -> data_tx_o == data_tx_i every cycle. Any frame/parity/overrun input gives error_o != 0 in the same cycle; interrupt_ackn_i clears it.
- Master configuration with std_config_i = 1:
  - config_req_mst_i -> config_req_mst_o high until req_done_i.
  - After ACKN, data_tx_o is D3, D4, D8, DC in turn (8'hD3, 8'hD4, 8'hD8, 8'hDC), each acked.
  - Ends with a configuration_done_o pulse and a return to MAIN.
- Slave configuration: config_req_slv_i -> req_ackn_o = 1. After req_ackn_i, data_tx_o == 8'hFF.
  - Rx D3, D4, D8, DC, each answered with 8'hFF.
  - config_o == 6'b110000; done pulse.
- Slave receives 8'h53 -> error_o[3] = 1, back in MAIN, config_o unchanged.
- Master with std_config_i = 0 and config_i = 6'b10_01_01 -> packets D2, D5, D9, DC; config_o updated.
- Reset asserted in WAIT_TX_MST -> outputs at reset values immediately, state MAIN.
